id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline; sits downstream of the fetch stage.
//  - Latches {PC, instruction} from fetch in an internal IF/ID register.
//  - Decodes the instruction and reads the 32x32 register file.
//  - Resolves branches and drives Br_taken/Br_offset back to fetch.
//  - Detects load-use hazards and drives a registered ID/EX bundle to execute.
// PARAMETERS
//  WIDTH      32  datapath and PC width
//  REG_COUNT  32  register file depth (R0 hardwired to zero)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous reset, active high
//  if_pc         in   32  PC from fetch (address of next sequential fetch)
//  if_instr      in   32  instruction from fetch
//  wb_en         in   1   write-back enable
//  wb_dest       in   5   write-back register index
//  wb_value      in   32  write-back data
//  exe_mem_r     in   1   instruction currently in EX is a load
//  exe_dest      in   5   destination register of the EX instruction
//  Br_taken      out  1   combinational: redirect fetch this cycle
//  Br_offset     out  16  combinational: signed word offset (imm[15:0])
//  freeze_if     out  1   combinational: hold the fetch PC (stall)
//  id_pc         out  32  registered PC to EX
//  id_val1       out  32  registered rs value
//  id_val2       out  32  registered rt value (rd value for ST)
//  id_imm        out  32  registered sign-extended imm[15:0]
//  id_dest       out  5   registered destination index
//  id_exe_cmd    out  4   registered ALU command
//  id_mem_r      out  1   registered load flag
//  id_mem_w      out  1   registered store flag
//  id_wb_en      out  1   registered write-back flag
// BEHAVIOUR
//  - Fields: op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0].
//  - Opcodes: NOP 0, ADD 1, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLA 9, SLL 10, SRA 11,
//    SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42.
//    Unknown opcodes decode as NOP.
//  - Reset: IF/ID latch = {0, NOP}; every id_* output = 0; all registers = 0;
//    Br_taken = 0, freeze_if = 0.
//  - Register file: write on posedge when wb_en && wb_dest != 0.
//    Same-cycle read of wb_dest returns wb_value (write-through bypass).
//    R0 always reads 0.
//  - Hazard: stall = exe_mem_r && exe_dest != 0 && (exe_dest == rs, or
//    exe_dest == rt_used), where rt_used = rt for R-type and rd for ST/BNE.
//  - Stall: freeze_if = 1; IF/ID latch holds; ID/EX loads a bubble (all flags 0);
//    Br_taken forced 0. Stall has priority over the branch.
//  - Branch, combinational in the cycle the branch sits in IF/ID:
//    BEZ taken if val(rs) == 0; BNE taken if val(rs) != val(rd); JMP always taken.
//    Br_offset = imm whenever op is BEZ, BNE or JMP; otherwise 0.
//  - Taken branch: the IF/ID latch loads NOP at the next edge (flushes the wrong-path
//    fetch). The branch itself enters ID/EX with all flags 0.
//  - Latency: one cycle IF/ID -> ID/EX. No internal FSM beyond the latches.
//  - Widths: id_imm = {{16{imm[15]}}, imm}. Register indices are 5 bits.
//  - Reset mid-operation clears all latches immediately; no partial state survives.
// STRUCTURE
//  - Shared package/header: opcode constants, EXE_CMD encodings
//    (MOV 1, ADD 0, SUB 2, AND 4, OR 5, NOR 6, XOR 7, SHL 8, SRA 9, SRL 10),
//    instruction field slice positions.
//  - One sub-module: reg_file (2 async read ports, 1 sync write port, bypass).
//  - Decode, hazard and branch logic are combinational inside id_stage.
// TESTING
//  - rst pulse mid-run -> all id_* = 0, Br_taken = 0 asynchronously;
//    R5 reads 0 afterwards.
//  - wb R3 <= 32'h1234 same cycle as ADD R1,R3,R3 in ID
//    -> id_val1 = id_val2 = 32'h1234 next edge.
//  - wb R0 <= 32'hFFFF -> later read of R0 = 0.
//  - BEZ rs=R2 (R2=0), imm=16'hFFFE -> Br_taken = 1, Br_offset = 16'hFFFE;
//    next cycle IF/ID holds NOP; branch flags in ID/EX are 0.
//  - exe_mem_r=1, exe_dest=4, ID = SUB R6,R4,R7 -> freeze_if = 1, ID/EX bubble,
//    SUB re-decoded when exe_mem_r drops.
//  - Load-use stall coincident with BNE on R4 -> Br_taken = 0 until the stall clears,
//    then resolves correctly.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the MIPS decode stage: instruction field slices,
// opcodes, ALU command encodings and the opcode-to-control decode helper.
package id_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OPC_NOP  = 6'd0;
  localparam logic [5:0] OPC_ADD  = 6'd1;
  localparam logic [5:0] OPC_SUB  = 6'd3;
  localparam logic [5:0] OPC_AND  = 6'd5;
  localparam logic [5:0] OPC_OR   = 6'd6;
  localparam logic [5:0] OPC_NOR  = 6'd7;
  localparam logic [5:0] OPC_XOR  = 6'd8;
  localparam logic [5:0] OPC_SLA  = 6'd9;
  localparam logic [5:0] OPC_SLL  = 6'd10;
  localparam logic [5:0] OPC_SRA  = 6'd11;
  localparam logic [5:0] OPC_SRL  = 6'd12;
  localparam logic [5:0] OPC_ADDI = 6'd32;
  localparam logic [5:0] OPC_SUBI = 6'd33;
  localparam logic [5:0] OPC_LD   = 6'd36;
  localparam logic [5:0] OPC_ST   = 6'd37;
  localparam logic [5:0] OPC_BEZ  = 6'd40;
  localparam logic [5:0] OPC_BNE  = 6'd41;
  localparam logic [5:0] OPC_JMP  = 6'd42;

  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_SUB = 4'd2;
  localparam logic [3:0] EXE_AND = 4'd4;
  localparam logic [3:0] EXE_OR  = 4'd5;
  localparam logic [3:0] EXE_NOR = 4'd6;
  localparam logic [3:0] EXE_XOR = 4'd7;
  localparam logic [3:0] EXE_SHL = 4'd8;
  localparam logic [3:0] EXE_SRA = 4'd9;
  localparam logic [3:0] EXE_SRL = 4'd10;

  typedef struct packed {
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       src2_rt;   // second operand is rt (R-type)
    logic       src2_rd;   // second operand is rd (ST data, BNE compare)
    logic       is_bez;
    logic       is_bne;
    logic       is_jmp;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OPC_ADD:  begin c.cmd = EXE_ADD; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_SUB:  begin c.cmd = EXE_SUB; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_AND:  begin c.cmd = EXE_AND; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_OR:   begin c.cmd = EXE_OR;  c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_NOR:  begin c.cmd = EXE_NOR; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_XOR:  begin c.cmd = EXE_XOR; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_SLA,
      OPC_SLL:  begin c.cmd = EXE_SHL; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_SRA:  begin c.cmd = EXE_SRA; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_SRL:  begin c.cmd = EXE_SRL; c.wb_en = 1'b1; c.src2_rt = 1'b1; end
      OPC_ADDI: begin c.cmd = EXE_ADD; c.wb_en = 1'b1; end
      OPC_SUBI: begin c.cmd = EXE_SUB; c.wb_en = 1'b1; end
      OPC_LD:   begin c.cmd = EXE_ADD; c.wb_en = 1'b1; c.mem_r = 1'b1; end
      OPC_ST:   begin c.cmd = EXE_ADD; c.mem_w = 1'b1; c.src2_rd = 1'b1; end
      OPC_BEZ:  c.is_bez = 1'b1;
      OPC_BNE:  begin c.is_bne = 1'b1; c.src2_rd = 1'b1; end
      OPC_JMP:  c.is_jmp = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32-entry register file: two asynchronous read ports with write-through bypass,
// one synchronous write port; entry 0 always reads zero.
module id_stage_reg_file #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    i_ra1,
  input  logic [AW-1:0]    i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd
);

  logic [WIDTH-1:0] r_regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // A value being written this cycle is visible to a reader in the same cycle.
  assign o_rd1 = (i_ra1 == '0)                ? '0   :
                 (i_we && (i_wa == i_ra1))    ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0)                ? '0   :
                 (i_we && (i_wa == i_ra2))    ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID latch, decode, register read, branch resolution,
// load-use hazard detection and the registered ID/EX bundle.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [31:0]      if_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  input  logic             exe_mem_r,
  input  logic [4:0]       exe_dest,
  output logic             Br_taken,
  output logic [15:0]      Br_offset,
  output logic             freeze_if,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_val1,
  output logic [WIDTH-1:0] id_val2,
  output logic [WIDTH-1:0] id_imm,
  output logic [4:0]       id_dest,
  output logic [3:0]       id_exe_cmd,
  output logic             id_mem_r,
  output logic             id_mem_w,
  output logic             id_wb_en
);

  logic [WIDTH-1:0]   r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;

  logic [5:0]        w_op;
  logic [REG_AW-1:0] w_rd, w_rs, w_rt, w_ra2;
  logic [15:0]       w_imm;
  ctrl_t             w_ctrl;
  logic [WIDTH-1:0]  w_val1, w_val2;
  logic              w_stall, w_cond, w_is_branch;

  assign w_op   = r_if_instr[OP_HI:OP_LO];
  assign w_rd   = r_if_instr[RD_HI:RD_LO];
  assign w_rs   = r_if_instr[RS_HI:RS_LO];
  assign w_rt   = r_if_instr[RT_HI:RT_LO];
  assign w_imm  = r_if_instr[IMM_HI:IMM_LO];
  assign w_ctrl = decode_ctrl(w_op);
  assign w_ra2  = w_ctrl.src2_rd ? w_rd : w_rt;

  id_stage_reg_file #(
    .WIDTH     (WIDTH),
    .REG_COUNT (REG_COUNT),
    .AW        (REG_AW)
  ) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_ra2),
    .o_rd1 (w_val1),
    .o_rd2 (w_val2),
    .i_we  (wb_en),
    .i_wa  (wb_dest),
    .i_wd  (wb_value)
  );

  assign w_stall = exe_mem_r && (exe_dest != '0) &&
                   ((exe_dest == w_rs) ||
                    ((w_ctrl.src2_rt || w_ctrl.src2_rd) && (exe_dest == w_ra2)));

  always_comb begin
    w_cond = 1'b0;
    if (w_ctrl.is_bez)      w_cond = (w_val1 == '0);
    else if (w_ctrl.is_bne) w_cond = (w_val1 != w_val2);
    else if (w_ctrl.is_jmp) w_cond = 1'b1;
  end

  assign w_is_branch = w_ctrl.is_bez || w_ctrl.is_bne || w_ctrl.is_jmp;
  // A stalled branch may be comparing a stale operand, so it must not redirect.
  assign Br_taken    = w_cond && !w_stall;
  assign Br_offset   = w_is_branch ? w_imm : '0;
  assign freeze_if   = w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else if (w_stall) begin
      r_if_pc    <= r_if_pc;
      r_if_instr <= r_if_instr;
    end else if (Br_taken) begin
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_if_pc    <= if_pc;
      r_if_instr <= if_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_stall) begin
      id_pc      <= '0;
      id_val1    <= '0;
      id_val2    <= '0;
      id_imm     <= '0;
      id_dest    <= '0;
      id_exe_cmd <= '0;
      id_mem_r   <= 1'b0;
      id_mem_w   <= 1'b0;
      id_wb_en   <= 1'b0;
    end else begin
      id_pc      <= r_if_pc;
      id_val1    <= w_val1;
      id_val2    <= w_val2;
      id_imm     <= {{(WIDTH-16){w_imm[15]}}, w_imm};
      id_dest    <= w_rd;
      id_exe_cmd <= w_ctrl.cmd;
      id_mem_r   <= w_ctrl.mem_r;
      id_mem_w   <= w_ctrl.mem_w;
      id_wb_en   <= w_ctrl.wb_en;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic
// against a behavioural model of the decode-stage rules.
module tb_id_stage;

  localparam logic [5:0] O_NOP = 6'd0,  O_ADD = 6'd1,  O_SUB = 6'd3,  O_AND = 6'd5;
  localparam logic [5:0] O_OR  = 6'd6,  O_NOR = 6'd7,  O_XOR = 6'd8,  O_SLA = 6'd9;
  localparam logic [5:0] O_SLL = 6'd10, O_SRA = 6'd11, O_SRL = 6'd12, O_ADDI = 6'd32;
  localparam logic [5:0] O_SUBI = 6'd33, O_LD = 6'd36, O_ST = 6'd37, O_BEZ = 6'd40;
  localparam logic [5:0] O_BNE = 6'd41, O_JMP = 6'd42, O_BAD = 6'd50;
  localparam logic [5:0] OPS [19] = '{O_NOP, O_ADD, O_SUB, O_AND, O_OR, O_NOR, O_XOR,
    O_SLA, O_SLL, O_SRA, O_SRL, O_ADDI, O_SUBI, O_LD, O_ST, O_BEZ, O_BNE, O_JMP, O_BAD};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr, wb_value;
  logic        wb_en, exe_mem_r;
  logic [4:0]  wb_dest, exe_dest;
  logic        Br_taken, freeze_if, id_mem_r, id_mem_w, id_wb_en;
  logic [15:0] Br_offset;
  logic [31:0] id_pc, id_val1, id_val2, id_imm;
  logic [4:0]  id_dest;
  logic [3:0]  id_exe_cmd;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_mem_r(exe_mem_r), .exe_dest(exe_dest),
    .Br_taken(Br_taken), .Br_offset(Br_offset), .freeze_if(freeze_if),
    .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2), .id_imm(id_imm),
    .id_dest(id_dest), .id_exe_cmd(id_exe_cmd), .id_mem_r(id_mem_r),
    .id_mem_w(id_mem_w), .id_wb_en(id_wb_en)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_if_pc, m_if_instr;
  bit          m_if_pc_ok;
  logic [31:0] e_pc, e_v1, e_v2, e_imm;
  logic [4:0]  e_dest;
  logic [3:0]  e_cmd;
  logic        e_mr, e_mw, e_wb;
  bit          c_pc, c_v1, c_v2, c_cmd, c_imm;

  function automatic bit is_rtype(input logic [5:0] op);
    return op inside {O_ADD, O_SUB, O_AND, O_OR, O_NOR, O_XOR, O_SLA, O_SLL, O_SRA, O_SRL};
  endfunction
  function automatic bit writes_back(input logic [5:0] op);
    return is_rtype(op) || (op inside {O_ADDI, O_SUBI, O_LD});
  endfunction
  function automatic bit known_op(input logic [5:0] op);
    return (op == O_NOP) || writes_back(op) || (op inside {O_ST, O_BEZ, O_BNE, O_JMP});
  endfunction
  function automatic logic [3:0] alu_cmd(input logic [5:0] op);
    case (op)
      O_SUB, O_SUBI: return 4'd2;
      O_AND:         return 4'd4;
      O_OR:          return 4'd5;
      O_NOR:         return 4'd6;
      O_XOR:         return 4'd7;
      O_SLA, O_SLL:  return 4'd8;
      O_SRA:         return 4'd9;
      O_SRL:         return 4'd10;
      default:       return 4'd0;
    endcase
  endfunction
  // Register value as seen this cycle, including the value being written back now.
  function automatic logic [31:0] rv(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_dest == a) return wb_value;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_if_pc = 32'd0; m_if_instr = 32'd0; m_if_pc_ok = 1'b1;
    e_mr = 1'b0; e_mw = 1'b0; e_wb = 1'b0;
    c_pc = 1'b0; c_v1 = 1'b0; c_v2 = 1'b0; c_cmd = 1'b0; c_imm = 1'b0;
  endtask

  task automatic model_comb(output bit stall, output bit taken, output logic [15:0] off);
    logic [5:0] op;
    logic [4:0] rd, rs, rt;
    bit hit2, cond;
    op = m_if_instr[31:26]; rd = m_if_instr[25:21];
    rs = m_if_instr[20:16]; rt = m_if_instr[15:11];
    hit2 = (is_rtype(op) && exe_dest == rt) || ((op == O_ST || op == O_BNE) && exe_dest == rd);
    stall = exe_mem_r && exe_dest != 5'd0 && (exe_dest == rs || hit2);
    cond = (op == O_BEZ && rv(rs) == 32'd0) || (op == O_BNE && rv(rs) != rv(rd)) || (op == O_JMP);
    taken = cond && !stall;
    off = (op inside {O_BEZ, O_BNE, O_JMP}) ? m_if_instr[15:0] : 16'd0;
  endtask

  task automatic model_clock(input bit stall, input bit taken);
    logic [5:0] op;
    logic [4:0] rd, rs, rt;
    op = m_if_instr[31:26]; rd = m_if_instr[25:21];
    rs = m_if_instr[20:16]; rt = m_if_instr[15:11];
    if (stall) begin
      e_mr = 1'b0; e_mw = 1'b0; e_wb = 1'b0;
      c_pc = 1'b0; c_v1 = 1'b0; c_v2 = 1'b0; c_cmd = 1'b0; c_imm = 1'b0;
    end else begin
      e_pc = m_if_pc;           c_pc = m_if_pc_ok;
      e_cmd = alu_cmd(op);      c_cmd = known_op(op);
      e_imm = {{16{m_if_instr[15]}}, m_if_instr[15:0]}; c_imm = known_op(op);
      e_wb = writes_back(op);   e_mr = (op == O_LD); e_mw = (op == O_ST);
      e_v1 = rv(rs);            c_v1 = writes_back(op) || op == O_ST;
      e_v2 = rv(op == O_ST ? rd : rt); c_v2 = is_rtype(op) || op == O_ST;
      e_dest = rd;
    end
    if (!stall) begin
      if (taken) begin
        m_if_instr = 32'd0; m_if_pc_ok = 1'b0;
      end else begin
        m_if_instr = if_instr; m_if_pc = if_pc; m_if_pc_ok = 1'b1;
      end
    end
    if (wb_en && wb_dest != 5'd0) m_regs[wb_dest] = wb_value;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction
  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    if_pc = 32'd0; if_instr = 32'd0; wb_en = 1'b0; wb_dest = 5'd0;
    wb_value = 32'd0; exe_mem_r = 1'b0; exe_dest = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] all_or;
    rst = 1'b1; clear_inputs();
    tick(); tick();
    all_or = id_pc | id_val1 | id_val2 | id_imm | {27'd0, id_dest} | {28'd0, id_exe_cmd};
    n_tests++;
    if (all_or !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", all_or); end
    n_tests++;
    if ({id_mem_r, id_mem_w, id_wb_en, Br_taken, freeze_if} !== 5'd0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {id_mem_r, id_mem_w, id_wb_en, Br_taken, freeze_if});
    end
    n_tests++;
    if (Br_offset !== 16'd0) begin n_fail++; $display("FAIL reset_offset got %0h exp 0", Br_offset); end
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    if_pc = 32'h100; if_instr = mk_r(O_ADD, 5'd1, 5'd3, 5'd3);
    tick();
    wb_en = 1'b1; wb_dest = 5'd3; wb_value = 32'h1234; if_instr = 32'd0;
    tick();
    wb_en = 1'b0;
    n_tests++;
    if (id_val1 !== 32'h1234 || id_val2 !== 32'h1234) begin
      n_fail++; $display("FAIL bypass_vals got %0h/%0h exp 1234/1234", id_val1, id_val2);
    end
    n_tests++;
    if ({id_wb_en, id_dest, id_exe_cmd, id_pc} !== {1'b1, 5'd1, 4'd0, 32'h100}) begin
      n_fail++; $display("FAIL bypass_ctrl got wb=%b dest=%0d cmd=%0d pc=%0h exp 1/1/0/100",
                         id_wb_en, id_dest, id_exe_cmd, id_pc);
    end
  endtask

  task automatic test_r0();
    wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hFFFF; if_instr = 32'd0;
    tick();
    wb_en = 1'b0; if_instr = mk_r(O_ADD, 5'd2, 5'd0, 5'd0);
    tick();
    wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hFFFF; if_instr = 32'd0;
    tick();
    wb_en = 1'b0;
    n_tests++;
    if (id_val1 !== 32'd0 || id_val2 !== 32'd0) begin
      n_fail++; $display("FAIL r0_read got %0h/%0h exp 0/0", id_val1, id_val2);
    end
  endtask

  task automatic test_branch();
    if_pc = 32'h200; if_instr = mk_i(O_BEZ, 5'd0, 5'd2, 16'hFFFE);
    tick();
    if_pc = 32'h204; if_instr = mk_r(O_ADD, 5'd1, 5'd3, 5'd3);
    #1;
    n_tests++;
    if (Br_taken !== 1'b1 || Br_offset !== 16'hFFFE) begin
      n_fail++; $display("FAIL bez_taken got %b/%0h exp 1/fffe", Br_taken, Br_offset);
    end
    tick();
    n_tests++;
    if ({id_mem_r, id_mem_w, id_wb_en} !== 3'b000 || id_imm !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL bez_idex got flags=%b imm=%0h exp 000/fffffffe",
                         {id_mem_r, id_mem_w, id_wb_en}, id_imm);
    end
    if_instr = 32'd0;
    #1;
    n_tests++;
    if (Br_taken !== 1'b0 || Br_offset !== 16'd0) begin
      n_fail++; $display("FAIL bez_flush_ifid got %b/%0h exp 0/0", Br_taken, Br_offset);
    end
    tick();
    n_tests++;
    if (id_wb_en !== 1'b0) begin n_fail++; $display("FAIL bez_flushed_wb got %b exp 0", id_wb_en); end
    // BEZ on a nonzero register (R3 holds 1234) falls through but still reports its offset
    if_instr = mk_i(O_BEZ, 5'd0, 5'd3, 16'h0007);
    tick();
    if_instr = 32'd0; #1;
    n_tests++;
    if (Br_taken !== 1'b0 || Br_offset !== 16'h0007) begin
      n_fail++; $display("FAIL bez_not_taken got %b/%0h exp 0/7", Br_taken, Br_offset);
    end
    tick();
  endtask

  task automatic test_stall();
    if_pc = 32'h300; if_instr = mk_r(O_SUB, 5'd6, 5'd4, 5'd7);
    tick();
    exe_mem_r = 1'b1; exe_dest = 5'd4; if_pc = 32'h304; if_instr = mk_r(O_ADD, 5'd1, 5'd3, 5'd3);
    #1;
    n_tests++;
    if (freeze_if !== 1'b1) begin n_fail++; $display("FAIL stall_freeze got %b exp 1", freeze_if); end
    tick();
    n_tests++;
    if ({id_mem_r, id_mem_w, id_wb_en} !== 3'b000) begin
      n_fail++; $display("FAIL stall_bubble got %b exp 000", {id_mem_r, id_mem_w, id_wb_en});
    end
    n_tests++;
    if (freeze_if !== 1'b1) begin n_fail++; $display("FAIL stall_hold got %b exp 1", freeze_if); end
    tick();
    exe_mem_r = 1'b0;
    #1;
    n_tests++;
    if (freeze_if !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b exp 0", freeze_if); end
    tick();
    n_tests++;
    if ({id_exe_cmd, id_wb_en, id_dest, id_pc} !== {4'd2, 1'b1, 5'd6, 32'h300}) begin
      n_fail++; $display("FAIL stall_redecode got cmd=%0d wb=%b dest=%0d pc=%0h exp 2/1/6/300",
                         id_exe_cmd, id_wb_en, id_dest, id_pc);
    end
    // IF/ID now holds ADD R1,R3,R3
    if_instr = 32'd0;
    exe_mem_r = 1'b1; exe_dest = 5'd0; #1;
    n_tests++;
    if (freeze_if !== 1'b0) begin n_fail++; $display("FAIL stall_dest0 got %b exp 0", freeze_if); end
    exe_dest = 5'd3; #1;
    n_tests++;
    if (freeze_if !== 1'b1) begin n_fail++; $display("FAIL stall_rt got %b exp 1", freeze_if); end
    exe_mem_r = 1'b0; #1;
    n_tests++;
    if (freeze_if !== 1'b0) begin n_fail++; $display("FAIL stall_noload got %b exp 0", freeze_if); end
    exe_dest = 5'd0;
    tick(); tick();
  endtask

  task automatic test_stall_branch();
    wb_en = 1'b1; wb_dest = 5'd1; wb_value = 32'd5; if_instr = 32'd0;
    tick();
    wb_en = 1'b0; if_pc = 32'h400; if_instr = mk_i(O_BNE, 5'd4, 5'd1, 16'h0010);
    tick();
    exe_mem_r = 1'b1; exe_dest = 5'd4; if_instr = mk_r(O_ADD, 5'd1, 5'd3, 5'd3);
    #1;
    n_tests++;
    if (Br_taken !== 1'b0 || freeze_if !== 1'b1) begin
      n_fail++; $display("FAIL bne_stalled got br=%b frz=%b exp 0/1", Br_taken, freeze_if);
    end
    tick();
    n_tests++;
    if (Br_taken !== 1'b0) begin n_fail++; $display("FAIL bne_stalled2 got %b exp 0", Br_taken); end
    exe_mem_r = 1'b0; #1;
    n_tests++;
    if (Br_taken !== 1'b1 || Br_offset !== 16'h0010 || freeze_if !== 1'b0) begin
      n_fail++; $display("FAIL bne_resolve got br=%b off=%0h frz=%b exp 1/10/0", Br_taken, Br_offset, freeze_if);
    end
    tick();
    if_instr = 32'd0;
    tick();
    n_tests++;
    if (id_wb_en !== 1'b0) begin n_fail++; $display("FAIL bne_flushed_wb got %b exp 0", id_wb_en); end
    exe_dest = 5'd0;
  endtask

  task automatic test_mid_reset();
    logic [31:0] all_or;
    wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'd77; if_pc = 32'h500;
    if_instr = mk_r(O_ADD, 5'd1, 5'd5, 5'd5);
    tick();
    wb_en = 1'b0; if_instr = mk_i(O_JMP, 5'd0, 5'd0, 16'h0040);
    tick();
    #1;
    n_tests++;
    if (id_val1 !== 32'd77 || Br_taken !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got val1=%0h br=%b exp 4d/1", id_val1, Br_taken);
    end
    rst = 1'b1; #1;
    all_or = id_pc | id_val1 | id_val2 | id_imm | {27'd0, id_dest} | {28'd0, id_exe_cmd};
    n_tests++;
    if (all_or !== 32'd0 || {id_mem_r, id_mem_w, id_wb_en, Br_taken} !== 4'd0) begin
      n_fail++; $display("FAIL async_reset got data=%0h flags=%b exp 0/0000", all_or,
                         {id_mem_r, id_mem_w, id_wb_en, Br_taken});
    end
    tick();
    rst = 1'b0; if_instr = mk_r(O_ADD, 5'd1, 5'd5, 5'd5);
    tick();
    if_instr = 32'd0;
    tick();
    n_tests++;
    if (id_val1 !== 32'd0 || id_val2 !== 32'd0) begin
      n_fail++; $display("FAIL r5_after_reset got %0h/%0h exp 0/0", id_val1, id_val2);
    end
  endtask

  task automatic test_random();
    bit s, t;
    logic [15:0] o, imm;
    logic [5:0] op;
    do_reset();
    model_reset();
    for (int k = 0; k < 800; k++) begin
      op = OPS[$urandom_range(0, 18)];
      imm = 16'($urandom);
      imm[15:11] = 5'($urandom_range(0, 7));
      if_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm};
      if_pc = $urandom;
      wb_en = 1'($urandom_range(0, 1));
      wb_dest = 5'($urandom_range(0, 7));
      wb_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      exe_mem_r = ($urandom_range(0, 3) == 0);
      exe_dest = 5'($urandom_range(0, 7));
      #1;
      model_comb(s, t, o);
      n_tests++;
      if (Br_taken !== t || Br_offset !== o || freeze_if !== s) begin
        n_fail++; $display("FAIL rnd_comb[%0d] got br=%b off=%0h frz=%b exp %b/%0h/%b",
                           k, Br_taken, Br_offset, freeze_if, t, o, s);
      end
      model_clock(s, t);
      tick();
      n_tests++;
      if ({id_mem_r, id_mem_w, id_wb_en} !== {e_mr, e_mw, e_wb}) begin
        n_fail++; $display("FAIL rnd_flags[%0d] got %b exp %b", k,
                           {id_mem_r, id_mem_w, id_wb_en}, {e_mr, e_mw, e_wb});
      end
      if (c_cmd) begin
        n_tests++;
        if (id_exe_cmd !== e_cmd) begin n_fail++; $display("FAIL rnd_cmd[%0d] got %0d exp %0d", k, id_exe_cmd, e_cmd); end
      end
      if (c_imm) begin
        n_tests++;
        if (id_imm !== e_imm) begin n_fail++; $display("FAIL rnd_imm[%0d] got %0h exp %0h", k, id_imm, e_imm); end
      end
      if (c_pc) begin
        n_tests++;
        if (id_pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %0h exp %0h", k, id_pc, e_pc); end
      end
      if (c_v1) begin
        n_tests++;
        if (id_val1 !== e_v1) begin n_fail++; $display("FAIL rnd_val1[%0d] got %0h exp %0h", k, id_val1, e_v1); end
      end
      if (c_v2) begin
        n_tests++;
        if (id_val2 !== e_v2) begin n_fail++; $display("FAIL rnd_val2[%0d] got %0h exp %0h", k, id_val2, e_v2); end
      end
      if (e_wb) begin
        n_tests++;
        if (id_dest !== e_dest) begin n_fail++; $display("FAIL rnd_dest[%0d] got %0d exp %0d", k, id_dest, e_dest); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_branch();
    test_stall();
    test_stall_branch();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
